// File: rtl/match_judge_pkg.sv
// match_judge_pkg: shared sizes and FSM state encoding for the card match judge.
package match_judge_pkg;
  localparam int NUM_CARDS  = 36;
  localparam int NUM_PAIRS  = 18;
  localparam int IDX_W      = 6;
  localparam int FACE_W_DEF = 4;
  localparam int PAIR_W     = 5;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EVAL  = 3'd1,
    S_HOLD  = 3'd2,
    S_PULSE = 3'd3,
    S_CLEAR = 3'd4
  } state_t;
endpackage

// File: rtl/match_judge_sel_encoder.sv
// sel_encoder: saturating popcount plus lowest/highest set index of the valid selection vector.
module sel_encoder
  import match_judge_pkg::*;
(
  input  logic [NUM_CARDS-1:0] i_vsel,
  output logic [1:0]           o_count,
  output logic [IDX_W-1:0]     o_lo,
  output logic [IDX_W-1:0]     o_hi
);
  always_comb begin
    o_count = '0;
    o_lo    = '0;
    o_hi    = '0;
    for (int i = NUM_CARDS - 1; i >= 0; i--) if (i_vsel[i]) o_lo = IDX_W'(i);
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (i_vsel[i]) begin
        o_hi    = IDX_W'(i);
        o_count = (o_count == 2'd3) ? o_count : o_count + 2'd1;
      end
    end
  end
endmodule

// File: rtl/match_judge.sv
// match_judge: judges two selected cards after a visible hold, pulsing ms/mf and tracking pairs left.
module match_judge
  import match_judge_pkg::*;
#(
  parameter int HOLD_CYCLES = 25000000,
  parameter int FACE_W      = FACE_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CARDS-1:0]        sel_bus,
  input  logic [NUM_CARDS-1:0]        hidden_bus,
  input  logic [NUM_CARDS*FACE_W-1:0] face_bus,
  output logic                        mf,
  output logic                        ms,
  output logic                        busy,
  output logic [PAIR_W-1:0]           pairs_left,
  output logic                        win
);
  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [IDX_W-1:0]    r_lo, r_hi;
  logic                r_match, r_ms, r_mf, r_win;
  logic [PAIR_W-1:0]   r_pairs;
  logic [NUM_CARDS-1:0] w_vsel;
  logic [1:0]          w_count;
  logic [IDX_W-1:0]    w_lo, w_hi;
  logic [FACE_W-1:0]   w_face_lo, w_face_hi;
  logic                w_go_pulse;
  logic                w_unused_idx;
  assign w_vsel       = sel_bus & ~hidden_bus;
  assign w_face_lo    = face_bus[w_lo*FACE_W +: FACE_W];
  assign w_face_hi    = face_bus[w_hi*FACE_W +: FACE_W];
  assign w_unused_idx = ^{r_lo, r_hi};
  sel_encoder u_enc (
    .i_vsel  (w_vsel),
    .o_count (w_count),
    .o_lo    (w_lo),
    .o_hi    (w_hi)
  );
  always_comb begin
    w_next     = r_state;
    w_go_pulse = 1'b0;
    case (r_state)
      S_IDLE:  w_next = (w_count >= 2'd2 && !r_win) ? S_EVAL : S_IDLE;
      S_EVAL:  w_next = S_HOLD;
      S_HOLD: begin
        w_go_pulse = (w_count >= 2'd2) && (r_cnt == '0);
        w_next     = (w_count < 2'd2) ? S_CLEAR : w_go_pulse ? S_PULSE : S_HOLD;
      end
      S_PULSE: w_next = S_CLEAR;
      S_CLEAR: w_next = (w_count == 2'd0) ? S_IDLE : S_CLEAR;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_match <= 1'b0;
      r_ms    <= 1'b0;
      r_mf    <= 1'b0;
      r_pairs <= PAIR_W'(NUM_PAIRS);
      r_win   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ms    <= w_go_pulse && r_match;
      r_mf    <= w_go_pulse && !r_match;
      if (r_state == S_EVAL) begin
        r_lo    <= w_lo;
        r_hi    <= w_hi;
        r_match <= (w_count == 2'd2) && (w_face_lo == w_face_hi);
        r_cnt   <= CW'(HOLD_CYCLES - 1);
      end else if (r_state == S_HOLD && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_pairs <= (r_ms && r_pairs != '0) ? r_pairs - 1'b1 : r_pairs;
      r_win   <= r_win | (r_pairs == '0);
    end
  end
  assign ms         = r_ms;
  assign mf         = r_mf;
  assign busy       = (r_state != S_IDLE);
  assign pairs_left = r_pairs;
  assign win        = r_win;
endmodule

// File: tb/tb_match_judge.sv
// tb_match_judge: randomized and directed checks of match_judge against a selection-level verdict model.
module tb_match_judge;
  localparam int HOLD = 4;
  localparam int PC   = HOLD + 2;
  localparam int NOBS = 12;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [35:0]  sel_bus = '0;
  logic [35:0]  hidden_bus = '0;
  logic [143:0] face_bus = '0;
  logic         mf, ms, busy, win;
  logic [4:0]   pairs_left;
  int           n_checks = 0;
  int           n_fail = 0;
  int           exp_pairs = 18;
  bit           exp_win = 0;
  logic         o_ms [0:NOBS-1];
  logic         o_mf [0:NOBS-1];
  logic         o_busy [0:NOBS-1];
  logic         o_win [0:NOBS-1];
  logic [4:0]   o_pl [0:NOBS-1];

  match_judge #(.HOLD_CYCLES(HOLD), .FACE_W(4)) dut (
    .clk(clk), .rst(rst), .sel_bus(sel_bus), .hidden_bus(hidden_bus), .face_bus(face_bus),
    .mf(mf), .ms(ms), .busy(busy), .pairs_left(pairs_left), .win(win)
  );

  always #5 clk = ~clk;

  // 0 = no verdict, 1 = success, 2 = failure
  function automatic int verdict(input logic [35:0] s, input logic [35:0] h, input logic [143:0] f);
    logic [35:0] v;
    int n, a, b;
    v = s & ~h;
    n = $countones(v);
    a = -1;
    b = -1;
    if (exp_win || n < 2) return 0;
    if (n > 2) return 2;
    for (int i = 0; i < 36; i++) if (v[i]) begin
      if (a < 0) a = i; else b = i;
    end
    return (f[a*4 +: 4] == f[b*4 +: 4]) ? 1 : 2;
  endfunction

  task automatic observe(input logic [35:0] s, input logic [35:0] h);
    sel_bus = s;
    hidden_bus = h;
    for (int k = 0; k < NOBS; k++) begin
      @(negedge clk);
      o_ms[k] = ms; o_mf[k] = mf; o_busy[k] = busy; o_pl[k] = pairs_left; o_win[k] = win;
    end
  endtask

  task automatic settle();
    @(posedge clk); #1;
    sel_bus = '0;
    hidden_bus = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    sel_bus = '0;
    hidden_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pairs = 18;
    exp_win = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ms, mf, busy, win} !== 4'b0000 || pairs_left !== 5'd18) begin
      n_fail++;
      $display("FAIL reset got ms=%b mf=%b busy=%b win=%b pl=%0d exp 0 0 0 0 18", ms, mf, busy, win, pairs_left);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [35:0] s, h;
    int v, p0;
    for (int t = 0; t < 4; t++) begin
      face_bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
      h = '0;
      case (t)
        0: begin s = 36'h21; face_bus[0 +: 4] = 4'h3; face_bus[20 +: 4] = 4'h3; end
        1: begin s = 36'h204; face_bus[8 +: 4] = 4'h1; face_bus[36 +: 4] = 4'h7; end
        2: begin s = 36'h90; h = 36'h10; end
        default: begin s = 36'he; face_bus[4 +: 12] = 12'h555; end
      endcase
      v = verdict(s, h, face_bus);
      p0 = exp_pairs;
      observe(s, h);
      for (int k = 0; k < NOBS; k++) begin
        n_checks += 4;
        if (o_ms[k] !== (v == 1 && k == PC)) begin
          n_fail++; $display("FAIL dir%0d ms cyc%0d got %b exp %b", t, k, o_ms[k], (v == 1 && k == PC));
        end
        if (o_mf[k] !== (v == 2 && k == PC)) begin
          n_fail++; $display("FAIL dir%0d mf cyc%0d got %b exp %b", t, k, o_mf[k], (v == 2 && k == PC));
        end
        if (o_busy[k] !== (v != 0 && k >= 1)) begin
          n_fail++; $display("FAIL dir%0d busy cyc%0d got %b exp %b", t, k, o_busy[k], (v != 0 && k >= 1));
        end
        if (o_pl[k] !== 5'((v == 1 && k > PC) ? p0 - 1 : p0)) begin
          n_fail++; $display("FAIL dir%0d pairs cyc%0d got %0d exp %0d", t, k, o_pl[k], (v == 1 && k > PC) ? p0 - 1 : p0);
        end
      end
      if (v == 1) exp_pairs--;
      settle();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d busy_after_clear got %b exp 0", t, busy);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    face_bus[0 +: 4] = 4'h3;
    face_bus[20 +: 4] = 4'h3;
    sel_bus = 36'h21;
    for (int k = 0; k < NOBS; k++) begin
      if (k == 3) begin
        @(posedge clk); #1;
        sel_bus = 36'h1;
      end
      @(negedge clk);
      n_checks += 2;
      if (ms !== 1'b0 || mf !== 1'b0) begin
        n_fail++; $display("FAIL abort pulse cyc%0d got ms=%b mf=%b exp 0 0", k, ms, mf);
      end
      if (busy !== (k >= 1)) begin
        n_fail++; $display("FAIL abort busy cyc%0d got %b exp %b", k, busy, (k >= 1));
      end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    face_bus[0 +: 4] = 4'h3;
    face_bus[20 +: 4] = 4'h3;
    sel_bus = 36'h21;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    sel_bus = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pairs = 18;
    exp_win = 0;
    for (int k = 4; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if ({ms, mf, busy} !== 3'b000 || pairs_left !== 5'd18) begin
        n_fail++; $display("FAIL rst_mid cyc%0d got ms=%b mf=%b busy=%b pl=%0d exp 0 0 0 18", k, ms, mf, busy, pairs_left);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [35:0] s, h;
    int v, p0, nb;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 36; i++) face_bus[i*4 +: 4] = 4'($urandom_range(0, 2));
      s = '0;
      nb = $urandom_range(1, 3);
      while ($countones(s) < nb) s[$urandom_range(0, 35)] = 1'b1;
      h = 36'($urandom) & 36'($urandom) & 36'($urandom);
      v = verdict(s, h, face_bus);
      p0 = exp_pairs;
      observe(s, h);
      for (int k = 0; k < NOBS; k++) begin
        n_checks += 4;
        if (o_ms[k] !== (v == 1 && k == PC)) begin
          n_fail++; $display("FAIL rnd%0d ms cyc%0d got %b exp %b", t, k, o_ms[k], (v == 1 && k == PC));
        end
        if (o_mf[k] !== (v == 2 && k == PC)) begin
          n_fail++; $display("FAIL rnd%0d mf cyc%0d got %b exp %b", t, k, o_mf[k], (v == 2 && k == PC));
        end
        if (o_busy[k] !== (v != 0 && k >= 1)) begin
          n_fail++; $display("FAIL rnd%0d busy cyc%0d got %b exp %b", t, k, o_busy[k], (v != 0 && k >= 1));
        end
        if (o_pl[k] !== 5'((v == 1 && k > PC) ? p0 - 1 : p0)) begin
          n_fail++; $display("FAIL rnd%0d pairs cyc%0d got %0d exp %0d", t, k, o_pl[k], (v == 1 && k > PC) ? p0 - 1 : p0);
        end
      end
      if (v == 1 && exp_pairs > 0) exp_pairs--;
      if (exp_pairs == 0) exp_win = 1;
      settle();
    end
  endtask

  task automatic test_win();
    logic [35:0] s;
    do_reset();
    face_bus = '0;
    for (int j = 0; j < 18; j++) begin
      s = '0;
      s[2*j] = 1'b1;
      s[2*j+1] = 1'b1;
      observe(s, '0);
      n_checks += 4;
      if (o_ms[PC] !== 1'b1) begin
        n_fail++; $display("FAIL win_seq%0d ms got %b exp 1", j, o_ms[PC]);
      end
      if (o_pl[PC+1] !== 5'(17 - j)) begin
        n_fail++; $display("FAIL win_seq%0d pairs got %0d exp %0d", j, o_pl[PC+1], 17 - j);
      end
      if (o_win[PC+1] !== 1'b0) begin
        n_fail++; $display("FAIL win_seq%0d win_early got %b exp 0", j, o_win[PC+1]);
      end
      if (o_win[PC+2] !== (j == 17)) begin
        n_fail++; $display("FAIL win_seq%0d win got %b exp %b", j, o_win[PC+2], (j == 17));
      end
      settle();
    end
    observe(36'h3, '0);
    for (int k = 0; k < NOBS; k++) begin
      n_checks++;
      if ({o_ms[k], o_mf[k], o_busy[k], o_win[k]} !== 4'b0001 || o_pl[k] !== 5'd0) begin
        n_fail++;
        $display("FAIL win_ignore cyc%0d got ms=%b mf=%b busy=%b win=%b pl=%0d exp 0 0 0 1 0", k, o_ms[k], o_mf[k], o_busy[k], o_win[k], o_pl[k]);
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid();
    test_random();
    test_win();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/match_judge.md
MATCH_JUDGE -- requirements
Module: match_judge

Interface
REQ-001 Parameter HOLD_CYCLES, default 25000000, number of cycles both selected cards stay visible before the verdict pulse (minimum 1).
REQ-002 Parameter FACE_W, default 4, width of one card face id.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sel_bus  input  36  per-card selected flags, bit i = card i.
REQ-007 hidden_bus  input  36  per-card hidden (already removed) flags.
REQ-008 face_bus  input  36*FACE_W  face id of card i in bits [i*FACE_W +: FACE_W].
REQ-009 mf  output  1  match-failure pulse, one cycle, drives card deselect.
REQ-010 ms  output  1  match-success pulse, one cycle, drives card hide.
REQ-011 busy  output  1  high while a verdict is pending or being cleared.
REQ-012 pairs_left  output  5  remaining unmatched pairs, 18 down to 0.
REQ-013 win  output  1  level, high once pairs_left reaches 0.

Function
REQ-014 Valid selection vector SHALL be vsel = sel_bus & ~hidden_bus; hidden cards never count as selected.
REQ-015 States: IDLE, EVAL, HOLD, PULSE, CLEAR, encoded in 3 bits.
REQ-016 IDLE: stay while popcount(vsel) < 2; go to EVAL on the first cycle popcount(vsel) >= 2 (cycle 0).
REQ-017 EVAL (cycle 1): register lowest and highest set indices of vsel; register match = (popcount == 2) and equal face ids; go to HOLD and load the hold counter with HOLD_CYCLES-1.
REQ-018 HOLD: decrement the counter each cycle; go to PULSE when it reads 0, so HOLD occupies exactly HOLD_CYCLES cycles.
REQ-019 PULSE (cycle HOLD_CYCLES+2): assert ms if match, else mf, for exactly this one cycle; go to CLEAR.
REQ-020 CLEAR: wait until popcount(vsel) == 0, then go to IDLE; ms and mf stay low.
REQ-021 popcount(vsel) > 2 (simultaneous selections) SHALL be judged a failure, and mf is pulsed.
REQ-022 If popcount(vsel) drops below 2 during HOLD (abort), go to CLEAR with no pulse.
REQ-023 ms and mf SHALL never be high in the same cycle; each is registered, with no combinational path from inputs.
REQ-024 busy = (state != IDLE).
REQ-025 pairs_left decrements by 1 in the cycle after each ms pulse; saturates at 0 and never wraps.
REQ-026 win registered: set in the cycle after pairs_left becomes 0; stays set until rst; while win is high, the FSM stays in IDLE.

Reset
REQ-027 Reset values: state IDLE, mf 0, ms 0, busy 0, pairs_left 18, win 0, hold counter 0, registered indices 0.
REQ-028 rst asserted mid-operation (any state) SHALL return to IDLE on the next edge; any pending pulse is cancelled.

Structure
REQ-029 Shared package holds NUM_CARDS = 36, NUM_PAIRS = 18, IDX_W = 6, default FACE_W, and the state encodings.
REQ-030 One sub-module sel_encoder (combinational) SHALL take the 36-bit vsel and return count (saturating at 3), lowest index and highest index.
REQ-031 The hold counter width SHALL be clog2(HOLD_CYCLES) + 1.

Verification (HOLD_CYCLES = 4)
REQ-032 Match: faces 0 and 5 = 4'h3, sel bits 0 and 5 set at cycle 0 -> ms high only at cycle 6; pairs_left 18 -> 17 at cycle 7; mf stays 0.
REQ-033 Mismatch: faces 2 = 4'h1, 9 = 4'h7, sel bits 2 and 9 -> mf high only at cycle 6, ms 0, pairs_left unchanged; busy stays high until sel is cleared.
REQ-034 Hidden masking: bit 4 hidden and selected, bit 7 selected -> FSM stays IDLE, busy 0, no pulse.
REQ-035 Triple select: bits 1, 2, 3 set in the same cycle with equal faces -> mf at cycle 6.
REQ-036 Abort and reset: deselect one card during HOLD -> no pulse, CLEAR; repeat and assert rst at cycle 3 -> IDLE at cycle 4, no pulse, pairs_left 18.
REQ-037 Win: 18 successive matches -> pairs_left reaches 0, win high one cycle later, and further selections are ignored.
